// File: rtl/ins_mem_loader.sv
// ----------------------------------------------------------------------------
// ins_mem_loader
//   Bulk writer for the byte-wide instruction memory. It takes a stream of
//   program words over a valid/ready handshake and writes them to consecutive
//   addresses starting at 0. It then reads every word back and compares a
//   16-bit additive checksum of the readback against the checksum accumulated
//   during the load.
//
// Ports
//   clock, reset     system clock; synchronous active-high reset
//   start, length    one-cycle load request and word count (sampled in IDLE)
//   in_valid/in_data incoming program words
//   in_ready         loader accepts in_data this cycle (LOAD only)
//   mem_writeEn      memory write strobe
//   mem_address      memory address (write address in LOAD, read in VERIFY)
//   mem_dataOut      memory write data
//   mem_dataIn       memory read data, one cycle after the address
//   busy             high during LOAD and VERIFY
//   done             one-cycle completion pulse
//   error, checksum  result; valid with done, held until the next start
// ----------------------------------------------------------------------------
module ins_mem_loader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  mem_writeEn,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0]      mem_dataOut,
  input  logic [WIDTH-1:0]      mem_dataIn,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           checksum
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [1:0]          r_state;
  logic [ADDR_WIDTH:0] r_len;
  logic [ADDR_WIDTH:0] r_wr_cnt;   // one bit wider than the address: counts up to DEPTH
  logic [ADDR_WIDTH:0] r_rd_cnt;
  logic                r_pipe;     // a read address was issued last cycle
  logic [15:0]         r_load_sum;
  logic [15:0]         r_read_sum;
  logic                r_error;
  logic [15:0]         r_checksum;

  logic        w_in_load;
  logic        w_in_verify;
  logic        w_accept;
  logic [15:0] w_data_ext;
  logic [15:0] w_rd_ext;
  logic [15:0] w_read_sum_nxt;

  assign w_in_load   = (r_state == S_LOAD);
  assign w_in_verify = (r_state == S_VERIFY);
  assign w_accept    = in_valid & w_in_load;
  assign w_data_ext  = 16'(in_data);
  assign w_rd_ext    = 16'(mem_dataIn);

  // The readback sum including the sample arriving this cycle; used both as
  // the next read_sum and for the final compare on the VERIFY->DONE edge.
  assign w_read_sum_nxt = r_pipe ? (r_read_sum + w_rd_ext) : r_read_sum;

  assign in_ready    = w_in_load;
  assign mem_writeEn = w_accept;
  assign mem_dataOut = w_in_load ? in_data : '0;
  assign busy        = w_in_load | w_in_verify;
  assign done        = (r_state == S_DONE);
  assign error       = r_error;
  assign checksum    = r_checksum;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    mem_address = '0;
    if (w_in_load) begin
      mem_address = r_wr_cnt[ADDR_WIDTH-1:0];
    end else if (w_in_verify) begin
      mem_address = r_rd_cnt[ADDR_WIDTH-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_pipe     <= 1'b0;
      r_load_sum <= '0;
      r_read_sum <= '0;
      r_error    <= 1'b0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pipe     <= 1'b0;
            r_load_sum <= '0;
            r_read_sum <= '0;
            r_checksum <= '0;
            if (length == '0) begin
              r_error <= 1'b0;
              r_state <= S_DONE;
            end else if (length > DEPTH_L) begin
              // Oversized request: report it without touching memory.
              r_error <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_len   <= length;
              r_error <= 1'b0;
              r_state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_wr_cnt   <= r_wr_cnt + CNT_ONE;
            r_load_sum <= r_load_sum + w_data_ext;
            if (r_wr_cnt == r_len - CNT_ONE) begin
              r_rd_cnt <= '0;
              r_pipe   <= 1'b0;
              r_state  <= S_VERIFY;
            end
          end
        end

        S_VERIFY: begin
          // Cycles 0..L-1 issue addresses; cycle L only collects the last
          // sample, so VERIFY spans L+1 cycles.
          r_read_sum <= w_read_sum_nxt;
          r_pipe     <= (r_rd_cnt < r_len);
          if (r_rd_cnt == r_len) begin
            r_error    <= (r_load_sum != w_read_sum_nxt);
            r_checksum <= r_load_sum;
            r_state    <= S_DONE;
          end else begin
            r_rd_cnt <= r_rd_cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_ins_mem_loader
//   Self-checking bench for ins_mem_loader. A behavioural memory with a
//   registered read port sits on the memory side (with an optional corrupted
//   readback location). Each transaction is described by its length, its word
//   list and the per-cycle in_valid pattern; the expected cycle-by-cycle
//   handshake, addresses, done timing, checksum and error flag are derived
//   from those with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_ins_mem_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef bit         bit_q_t[$];

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  length;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_writeEn;
  logic [7:0]  mem_address;
  logic [7:0]  mem_dataOut;
  logic [7:0]  mem_dataIn;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int tests = 0;
  int fails = 0;

  // Memory model with a registered read and an optional bad readback word.
  logic [7:0] mem [0:255];
  logic [7:0] rd_q;
  logic [7:0] rd_addr_q;
  logic       corrupt_en  = 1'b0;
  logic [7:0] corrupt_addr = '0;
  logic [7:0] corrupt_val  = '0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_writeEn) mem[mem_address] <= mem_dataOut;
    rd_q      <= mem[mem_address];
    rd_addr_q <= mem_address;
  end

  assign mem_dataIn = (corrupt_en && rd_addr_q == corrupt_addr) ? corrupt_val : rd_q;

  ins_mem_loader #(.WIDTH(8), .DEPTH(256)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .length      (length),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_writeEn (mem_writeEn),
    .mem_address (mem_address),
    .mem_dataOut (mem_dataOut),
    .mem_dataIn  (mem_dataIn),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .checksum    (checksum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete transaction starting in IDLE, called just after a rising edge.
  task automatic run_txn(input string name, input int len, input byte_q_t words,
                         input bit_q_t vflag, input int c_addr,
                         input logic [7:0] c_val, input bit ign);
    bit          valid_len;
    int          load_end, busy_end, done_cyc, widx;
    logic [15:0] sum_w, sum_r;
    logic        exp_err;
    logic [15:0] exp_ck;
    bit          pres;

    valid_len = (len >= 1 && len <= 256);
    load_end  = valid_len ? vflag.size() : 0;
    busy_end  = valid_len ? load_end + len + 1 : 0;
    done_cyc  = valid_len ? load_end + len + 2 : 1;
    sum_w = '0;
    sum_r = '0;
    if (valid_len) begin
      for (int i = 0; i < len; i++) begin
        sum_w = sum_w + 16'(words[i]);
        sum_r = sum_r + 16'((c_addr == i) ? c_val : words[i]);
      end
    end
    exp_err = valid_len ? (sum_w != sum_r) : (len > 256);
    exp_ck  = valid_len ? sum_w : 16'h0;

    corrupt_en   = (c_addr >= 0);
    corrupt_addr = 8'(c_addr);
    corrupt_val  = c_val;

    // Cycle 0: the start request, seen in IDLE.
    start    = 1'b1;
    length   = 9'(len);
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    @(negedge clock);
    check({name, ".idle_busy"},  busy,     1'b0);
    check({name, ".idle_ready"}, in_ready, 1'b0);
    tick();

    widx = 0;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      start  = (ign && c <= done_cyc) ? ($urandom_range(0, 2) == 0) : 1'b0;
      length = 9'($urandom_range(0, 300));
      pres   = (c <= load_end) ? vflag[c-1] : 1'b0;
      in_valid = (c <= load_end) ? pres : 1'($urandom_range(0, 1));
      in_data  = pres ? words[widx] : 8'($urandom_range(0, 255));
      @(negedge clock);
      check($sformatf("%s.ready c%0d", name, c), in_ready,    c <= load_end);
      check($sformatf("%s.busy c%0d",  name, c), busy,        c <= busy_end);
      check($sformatf("%s.done c%0d",  name, c), done,        c == done_cyc);
      check($sformatf("%s.we c%0d",    name, c), mem_writeEn, pres);
      if (pres) begin
        check($sformatf("%s.waddr c%0d", name, c), mem_address, widx);
        check($sformatf("%s.wdata c%0d", name, c), mem_dataOut, words[widx]);
      end
      if (valid_len && c > load_end && c - load_end - 1 < len)
        check($sformatf("%s.raddr c%0d", name, c), mem_address, c - load_end - 1);
      if (c >= done_cyc) begin
        check($sformatf("%s.addr0 c%0d", name, c), mem_address, 8'h00);
        check($sformatf("%s.error c%0d", name, c), error,       exp_err);
        check($sformatf("%s.cksum c%0d", name, c), checksum,    exp_ck);
      end
      if (pres) widx++;
      tick();
    end
    start      = 1'b0;
    in_valid   = 1'b0;
    corrupt_en = 1'b0;

    if (valid_len)
      for (int i = 0; i < len; i++)
        check($sformatf("%s.mem[%0d]", name, i), mem[i], words[i]);
  endtask

  task automatic gap_pattern(input int len, input int gap_den, output bit_q_t v);
    v = {};
    for (int i = 0; i < len; i++) begin
      while (gap_den > 0 && $urandom_range(0, gap_den - 1) == 0) v.push_back(1'b0);
      v.push_back(1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t w;
    bit_q_t  v;
    int      n;

    reset    = 1'b1;
    start    = 1'b0;
    length   = '0;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    @(negedge clock);
    check("rst.ready", in_ready,    1'b0);
    check("rst.we",    mem_writeEn, 1'b0);
    check("rst.addr",  mem_address, 8'h00);
    check("rst.dout",  mem_dataOut, 8'h00);
    check("rst.busy",  busy,        1'b0);
    check("rst.done",  done,        1'b0);
    check("rst.error", error,       1'b0);
    check("rst.cksum", checksum,    16'h0);
    reset = 1'b0;
    tick();

    // Four words with a one-cycle bubble after the second.
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    run_txn("four", 4, w, v, -1, 8'h00, 1'b0);

    // Full depth, streaming: done lands 2*256+3 cycles after start inclusive.
    w = {};
    v = {};
    for (int i = 0; i < 256; i++) begin
      w.push_back(8'hFF);
      v.push_back(1'b1);
    end
    run_txn("full", 256, w, v, -1, 8'h00, 1'b0);

    // Zero length and oversized length.
    w = {};
    v = {};
    run_txn("len0",   0,   w, v, -1, 8'h00, 1'b0);
    run_txn("len257", 257, w, v, -1, 8'h00, 1'b0);

    // Readback corruption at address 2.
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    v = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_txn("corrupt", 4, w, v, 2, 8'h34, 1'b0);

    // Reset after two of four words.
    start    = 1'b1;
    length   = 9'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA1;
    tick();
    in_data  = 8'hB2;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    @(negedge clock);
    check("mrst.ready", in_ready,    1'b0);
    check("mrst.we",    mem_writeEn, 1'b0);
    check("mrst.addr",  mem_address, 8'h00);
    check("mrst.dout",  mem_dataOut, 8'h00);
    check("mrst.busy",  busy,        1'b0);
    check("mrst.done",  done,        1'b0);
    check("mrst.error", error,       1'b0);
    check("mrst.cksum", checksum,    16'h0);
    check("mrst.mem0",  mem[0],      8'hA1);
    check("mrst.mem1",  mem[1],      8'hB2);
    tick();
    w = '{8'h5A};
    v = '{1'b1};
    run_txn("after_rst", 1, w, v, -1, 8'h00, 1'b0);

    // Starts pulsed while busy and in DONE must be ignored.
    w = {};
    for (int i = 0; i < 6; i++) w.push_back(8'($urandom_range(0, 255)));
    gap_pattern(6, 3, v);
    run_txn("ign_start", 6, w, v, -1, 8'h00, 1'b1);

    // Randomised transactions.
    for (int t = 0; t < 10; t++) begin
      n = (t == 9) ? int'($urandom_range(257, 511)) : int'($urandom_range(1, 40));
      w = {};
      for (int i = 0; i < n && n <= 256; i++) w.push_back(8'($urandom_range(0, 255)));
      if (n <= 256) gap_pattern(n, 4, v);
      else v = {};
      run_txn($sformatf("rnd%0d", t), n, w, v,
              ($urandom_range(0, 2) == 0 && n <= 256) ? int'($urandom_range(0, n - 1)) : -1,
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
